// File: rtl/cdc_fifo_packetizer_if.sv
// Push-side and stream-side signals of the A-domain packetizer.
// The packetizer takes the master view. The upstream source and the CDC FIFO
// take the slave view.
interface cdc_fifo_packetizer_if #(
    parameter int DataWidth = 32
);
    logic                 S_Valid_DA;
    logic                 S_Ready_DA;
    logic [DataWidth-1:0] S_Data_DA;
    logic                 S_Last_DA;
    logic                 Push_DA;
    logic [DataWidth-1:0] DataIn_DA;
    logic                 FifoFull_DA;
    logic                 Truncated_DA;
    logic [15:0]          PacketCount_DA;

    modport master (
        input  S_Valid_DA,
        input  S_Data_DA,
        input  S_Last_DA,
        input  FifoFull_DA,
        output S_Ready_DA,
        output Push_DA,
        output DataIn_DA,
        output Truncated_DA,
        output PacketCount_DA
    );

    modport slave (
        output S_Valid_DA,
        output S_Data_DA,
        output S_Last_DA,
        output FifoFull_DA,
        input  S_Ready_DA,
        input  Push_DA,
        input  DataIn_DA,
        input  Truncated_DA,
        input  PacketCount_DA
    );
endinterface

// File: rtl/cdc_fifo_packetizer.sv
// A-domain packetizer in front of the CDC FIFO push port.
// It buffers one upstream frame of up to MaxPacketLen words. It then pushes one
// header word {seq, zeros, len}, followed by the buffered payload words.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | buffer empty, ready for the first word of a packet
// ST_COLLECT | partial packet buffered, still accepting upstream words
// ST_HEADER  | offering the header word to the FIFO
// ST_PAYLOAD | offering pkt_buf_q[idx_q] to the FIFO
module cdc_fifo_packetizer #(
    parameter int DataWidth    = 32,
    parameter int MaxPacketLen = 16,
    parameter int SeqWidth     = 8
) (
    input  logic                    clk_DA,
    input  logic                    rst,
    cdc_fifo_packetizer_if.master   bus
);
    localparam int LenW = $clog2(MaxPacketLen + 1);
    localparam int IdxW = (MaxPacketLen > 1) ? $clog2(MaxPacketLen) : 1;

    generate
        if (DataWidth < SeqWidth + LenW) begin : g_bad_cfg
            $error("cdc_fifo_packetizer: DataWidth too small for header fields");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HEADER,
        ST_PAYLOAD
    } state_t;

    state_t                state_q, state_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [SeqWidth-1:0]   seq_q, seq_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  truncated_q, truncated_d;
    logic [DataWidth-1:0]  pkt_buf_q [MaxPacketLen];

    logic                  buf_we;
    logic                  s_ready;
    logic                  push;
    logic [DataWidth-1:0]  data_in;
    logic [DataWidth-1:0]  header;
    logic                  last_idx;

    // Header word: sequence number in the top bits, length in the low bits.
    always_comb begin
        header = '0;
        header[DataWidth-1 -: SeqWidth] = seq_q;
        header[LenW-1:0] = len_q;
    end

    assign last_idx = ((LenW'(idx_q) + LenW'(1)) == len_q);

    // Next-state and output decode. Push and DataIn depend only on registered state.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        pkt_cnt_d   = pkt_cnt_q;
        truncated_d = 1'b0;
        buf_we      = 1'b0;
        s_ready     = 1'b0;
        push        = 1'b0;
        data_in     = '0;
        unique case (state_q)
            ST_IDLE, ST_COLLECT: begin
                s_ready = 1'b1;
                if (bus.S_Valid_DA) begin
                    buf_we = 1'b1;
                    len_d  = len_q + LenW'(1);
                    if (bus.S_Last_DA) begin
                        state_d = ST_HEADER;
                    end else if (len_q == LenW'(MaxPacketLen - 1)) begin
                        // Force-close a full buffer. The rest of the frame becomes the next packet.
                        state_d     = ST_HEADER;
                        truncated_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_HEADER: begin
                push    = 1'b1;
                data_in = header;
                if (!bus.FifoFull_DA) begin
                    idx_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                push    = 1'b1;
                data_in = pkt_buf_q[idx_q];
                if (!bus.FifoFull_DA) begin
                    if (last_idx) begin
                        len_d     = '0;
                        seq_d     = seq_q + SeqWidth'(1);
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state register, async reset discards any partial packet.
    always_ff @(posedge clk_DA or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            seq_q       <= '0;
            pkt_cnt_q   <= '0;
            truncated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            pkt_cnt_q   <= pkt_cnt_d;
            truncated_q <= truncated_d;
        end
    end

    // Payload storage. Its contents are meaningless until written, so it needs no reset.
    always_ff @(posedge clk_DA) begin
        if (buf_we) begin
            pkt_buf_q[len_q[IdxW-1:0]] <= bus.S_Data_DA;
        end
    end

    assign bus.S_Ready_DA     = s_ready;
    assign bus.Push_DA        = push;
    assign bus.DataIn_DA      = data_in;
    assign bus.Truncated_DA   = truncated_q;
    assign bus.PacketCount_DA = pkt_cnt_q;
endmodule

// File: doc/cdc_fifo_packetizer.md
Name: cdc_fifo_packetizer

Overview:
- A-domain transmitter that sits in front of the CDC FIFO push port.
- Accepts a framed valid/ready stream (S_*) in clk_DA.
- Buffers one frame locally and emits it to the FIFO as one header word followed by the payload words.
- Honours FifoFull_DA backpressure, so the B-domain consumer can delimit packets without a sideband "last" crossing the domain.

Parameters:
- DataWidth, 32, width of payload words and FIFO words.
- MaxPacketLen, 16, maximum payload words per packet (>=1); frames longer than this are split.
- SeqWidth, 8, width of the packet sequence number carried in the header.
- Constraint: DataWidth >= SeqWidth + $clog2(MaxPacketLen+1); elaboration error otherwise.

Ports:
- clk_DA  in  1  A-domain clock
- rst  in  1  reset, asynchronous, active-high
- S_Valid_DA  in  1  upstream word valid
- S_Ready_DA  out  1  block accepts the upstream word this cycle
- S_Data_DA  in  DataWidth  upstream payload word
- S_Last_DA  in  1  final word of the upstream frame
- Push_DA  out  1  push request to the CDC FIFO
- DataIn_DA  out  DataWidth  word offered to the CDC FIFO
- FifoFull_DA  in  1  CDC FIFO full; a push is taken only when Push_DA & !FifoFull_DA
- Truncated_DA  out  1  one-cycle pulse: a packet was force-closed at MaxPacketLen
- PacketCount_DA  out  16  count of packets fully pushed; wraps

Behaviour:
- Reset (rst high, asynchronous): state IDLE, Len=0, Idx=0, Seq=0, PacketCount_DA=0, Truncated_DA=0.
  - Push_DA=0 and DataIn_DA=0 immediately.
  - S_Ready_DA=1 once reset releases.
- State IDLE (Len==0) and COLLECT (Len>0):
  - S_Ready_DA=1.
  - Accept = S_Valid_DA & S_Ready_DA: Buf[Len] <= S_Data_DA, Len++.
  - Accepted word with S_Last_DA=1 -> HEADER next cycle.
  - Accepted word that makes Len==MaxPacketLen with S_Last_DA=0 -> HEADER and Truncated_DA pulses for one cycle.
  - After a split, the remaining upstream words form the next packet with a new Seq.
  - Push_DA=0.
- State HEADER:
  - S_Ready_DA=0, Push_DA=1.
  - DataIn_DA = {Seq in bits [DataWidth-1 -: SeqWidth], zeros, Len in the low $clog2(MaxPacketLen+1) bits}.
  - On Push_DA & !FifoFull_DA: Idx=0 -> PAYLOAD.
- State PAYLOAD:
  - S_Ready_DA=0, Push_DA=1, DataIn_DA=Buf[Idx].
  - On accept with Idx<Len-1: Idx++.
  - On accept with Idx==Len-1: Len=0, Seq++ (mod 2^SeqWidth), PacketCount_DA++, go to IDLE.
  - S_Ready_DA becomes 1 in the next cycle.
- FifoFull_DA high: Push_DA and DataIn_DA hold stable and no state advances.
  - Push_DA never drops mid-packet for any reason other than reset.
- Push_DA and DataIn_DA are decoded combinationally from registered state only; there is no combinational path from FifoFull_DA to Push_DA.
- Latency, no backpressure:
  - Final upstream word accepted at edge N -> header offered in cycle N+1 -> payload word k offered in cycle N+2+k.
  - IDLE is re-entered after edge N+1+Len.
- Zero-length packets are never generated. A lone S_Last_DA with S_Valid_DA=0 is ignored.
- Reset mid-packet: the partial frame is discarded and Push_DA drops asynchronously. The CDC FIFO shares rst, so no partial packet survives.
- PacketCount_DA wraps 0xFFFF -> 0. Seq wraps 2^SeqWidth-1 -> 0.

Test Plan:
- Single word, FifoFull=0: S_Data=0xA5A5A5A5 with Last at edge 0.
  - Required: cycle 1 Push=1, DataIn=0x00000001 (Seq 0, Len 1).
  - Cycle 2: DataIn=0xA5A5A5A5.
  - Cycle 3: Push=0, S_Ready=1, PacketCount=1.
- Three-word frame 0x11, 0x22, 0x33 sent after the first packet.
  - Required header 0x01000003, then 0x11, 0x22, 0x33 on consecutive cycles.
  - S_Ready=0 for those 4 cycles.
- Backpressure: FifoFull=1 for 5 cycles while in HEADER.
  - Required: Push=1 and DataIn unchanged throughout; header accepted on the first cycle with FifoFull=0; payload order intact.
- Truncation, MaxPacketLen=4: 6-word frame with Last on word 6.
  - Required: Truncated pulses once; packet Seq0 Len4, then packet Seq1 Len2 carrying words 5 and 6.
- Wrap, SeqWidth=2: send 5 packets.
  - Required header Seq fields 0, 1, 2, 3, 0; PacketCount=5.
- Reset mid-PAYLOAD: assert rst after payload word 1 of 3.
  - Required: Push=0 within the same cycle, PacketCount=0.
  - The next frame's header carries Seq=0.
